// File: rtl/multiplicador_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encodings,
// operand width and iteration count.
`ifndef MULTIPLICADOR_SEQ_PKG_SV
`define MULTIPLICADOR_SEQ_PKG_SV

package multiplicador_seq_pkg;

  localparam int WIDTH      = 8;
  localparam int ITERATIONS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

`endif

// File: rtl/somador_8bits.sv
// 8-bit unsigned ripple adder with carry-out; the only arithmetic unit of the
// multiplier datapath.
`ifndef SOMADOR_8BITS_SV
`define SOMADOR_8BITS_SV

module somador_8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] s,
  output logic       c
);

  assign {c, s} = {1'b0, a} + {1'b0, b};

endmodule

`endif

// File: rtl/multiplicador_seq.sv
// Sequential 8x8 unsigned shift-add multiplier (8 CALC cycles per product).
// Optional MULT_ZERO_BYPASS_EN: zero operands skip CALC and complete in one cycle.
module multiplicador_seq
  import multiplicador_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  state_t             state, state_next;
  logic [WIDTH-1:0]   m, q, h;
  logic [2:0]         count;
  logic [2*WIDTH-1:0] p_reg;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [WIDTH-1:0]   h_step, q_step;
  logic               last_iter;
  logic               zero_op;

  somador_8bits u_somador (
    .a (h),
    .b (m),
    .s (sum),
    .c (carry)
  );

  assign last_iter = (count == 3'(ITERATIONS - 1));
  assign zero_op   = (A == '0) || (B == '0);

  // One shift-add step; the adder carry becomes the new H MSB so 255*255 fits.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    h_step = {1'b0, h[WIDTH-1:1]};
    q_step = {h[0], q[WIDTH-1:1]};
    if (q[0]) begin
      h_step = {carry, sum[WIDTH-1:1]};
      q_step = {sum[0], q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
`ifdef MULT_ZERO_BYPASS_EN
          state_next = zero_op ? DONE : CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m     <= '0;
      q     <= '0;
      h     <= '0;
      count <= '0;
      p_reg <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (start) begin
            m     <= A;
            q     <= B;
            h     <= '0;
            count <= '0;
`ifdef MULT_ZERO_BYPASS_EN
            if (zero_op) p_reg <= '0;
`endif
          end
        end
        CALC: begin
          h     <= h_step;
          q     <= q_step;
          count <= count + 3'd1;
          if (last_iter) p_reg <= {h_step, q_step};
        end
        default: ;
      endcase
    end
  end

  // The unused bypass wire stays referenced in the default build.
  logic unused_zero_op;
  assign unused_zero_op = zero_op;

  assign busy = (state == CALC);
  assign done = (state == DONE);
  assign P    = p_reg;

endmodule
